// File: rtl/mem_pkg.sv
// Shared definitions for the memory card board: layout table, FSM states,
// and the result codes exchanged with the turn/score stage.
package mem_pkg;

    localparam int NUM_POS = 16;

    // Base layout; values 0-7 each appear exactly twice. Index 0 is the LSB slot.
    localparam logic [NUM_POS-1:0][3:0] BOARD_INIT = {
        4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0,
        4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0
    };

    typedef enum logic [2:0] {
        ST_PICK1,
        ST_PICK2,
        ST_HOLD,
        ST_RESOLVE,
        ST_OVER
    } fsm_e;

    localparam logic [1:0] TR_NONE = 2'b00;
    localparam logic [1:0] TR_DONE = 2'b01;
    localparam logic [1:0] TR_WIN  = 2'b10;
    localparam logic [1:0] TR_TIE  = 2'b11;

    // Card value at a board position for a given layout rotation (mod 16 by width).
    function automatic logic [3:0] card_at(input logic [3:0] pos, input logic [3:0] shuf);
        logic [3:0] idx;
        idx = pos + shuf;
        return BOARD_INIT[idx];
    endfunction

endpackage

// File: rtl/card_board_if.sv
// Button/turn-result inputs and board display/strobe outputs of card_board.
interface card_board_if;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_sel;
    logic [1:0]  turn_res;
    logic        select;
    logic [3:0]  state;
    logic        empty;
    logic        player;
    logic [3:0]  cursor;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic        game_over;

    // Side that drives the buttons and turn result (buttons block / testbench).
    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_sel, turn_res,
        input  select, state, empty, player, cursor, face_up, matched, game_over
    );

    // The board itself.
    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_sel, turn_res,
        output select, state, empty, player, cursor, face_up, matched, game_over
    );
endinterface

// File: rtl/cursor_nav.sv
// 4x4 cursor: row/column kept as 2-bit fields so moves wrap naturally.
module cursor_nav (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic [3:0] cursor_o
);

    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;

    // At most one move per cycle, priority up > down > left > right.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (en_i) begin
            if (up_i)         row_d = row_q - 2'd1;
            else if (down_i)  row_d = row_q + 2'd1;
            else if (left_i)  col_d = col_q - 2'd1;
            else if (right_i) col_d = col_q + 2'd1;
        end
    end

    // Cursor register, homes to position 0 on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= 2'd0;
            col_q <= 2'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign cursor_o = {row_q, col_q};

endmodule

// File: rtl/card_board.sv
// Memory-game board: cursor, two-card pick, hold, resolve and game-over control.
module card_board
    import mem_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   shuffle,
    card_board_if.slave  bus
);

    localparam int             CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);

    fsm_e          fsm_q, fsm_d;
    logic [3:0]    shuffle_q;
    logic          select_q, select_d;
    logic          player_q, player_d;
    logic [15:0]   face_up_q, face_up_d;
    logic [15:0]   matched_q, matched_d;
    logic          game_over_q, game_over_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [3:0]    pos1_q, pos1_d;
    logic [3:0]    pos2_q, pos2_d;
    logic [3:0]    last_q, last_d;

    logic [3:0]    cursor;
    logic          empty;
    logic          pick;
    logic          force_over;

    cursor_nav u_nav (
        .clk      (clk),
        .rst      (rst),
        .en_i     (fsm_q != ST_OVER),
        .up_i     (bus.btn_up),
        .down_i   (bus.btn_down),
        .left_i   (bus.btn_left),
        .right_i  (bus.btn_right),
        .cursor_o (cursor)
    );

    assign empty = ~(face_up_q[cursor] | matched_q[cursor]);
    assign pick  = bus.btn_sel & empty;

    // Decode the turn/score stage result: winner or tie ends the game.
    always_comb begin
        force_over = 1'b0;
        case (bus.turn_res)
            TR_WIN, TR_TIE:   force_over = 1'b1;
            TR_NONE, TR_DONE: force_over = 1'b0;
            default:          force_over = 1'b0;
        endcase
    end

    // Next-state logic for the pick/hold/resolve sequence and board flags.
    always_comb begin
        fsm_d     = fsm_q;
        select_d  = 1'b0;
        player_d  = player_q;
        face_up_d = face_up_q;
        matched_d = matched_q;
        hold_d    = hold_q;
        pos1_d    = pos1_q;
        pos2_d    = pos2_q;
        last_d    = last_q;
        if (force_over) begin
            fsm_d = ST_OVER;
        end else begin
            case (fsm_q)
                ST_PICK1: if (pick) begin
                    select_d          = 1'b1;
                    face_up_d[cursor] = 1'b1;
                    pos1_d            = cursor;
                    last_d            = cursor;
                    fsm_d             = ST_PICK2;
                end
                ST_PICK2: if (pick) begin
                    select_d          = 1'b1;
                    face_up_d[cursor] = 1'b1;
                    pos2_d            = cursor;
                    last_d            = cursor;
                    hold_d            = '0;
                    fsm_d             = ST_HOLD;
                end
                ST_HOLD: begin
                    // Saturating count: leaves on the last hold cycle, never wraps.
                    if (hold_q >= HOLD_LAST) fsm_d = ST_RESOLVE;
                    else                     hold_d = hold_q + CW'(1);
                end
                ST_RESOLVE: begin
                    face_up_d[pos1_q] = 1'b0;
                    face_up_d[pos2_q] = 1'b0;
                    if (card_at(pos1_q, shuffle_q) == card_at(pos2_q, shuffle_q)) begin
                        matched_d[pos1_q] = 1'b1;
                        matched_d[pos2_q] = 1'b1;
                    end else begin
                        player_d = ~player_q;
                    end
                    fsm_d = (&matched_d) ? ST_OVER : ST_PICK1;
                end
                ST_OVER: fsm_d = ST_OVER;
                default: fsm_d = ST_PICK1;
            endcase
        end
        game_over_d = (fsm_d == ST_OVER);
    end

    // State registers; reset abandons any turn in progress and latches the layout.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_PICK1;
            shuffle_q   <= shuffle;
            select_q    <= 1'b0;
            player_q    <= 1'b0;
            face_up_q   <= '0;
            matched_q   <= '0;
            game_over_q <= 1'b0;
            hold_q      <= '0;
            pos1_q      <= '0;
            pos2_q      <= '0;
            last_q      <= '0;
        end else begin
            fsm_q       <= fsm_d;
            select_q    <= select_d;
            player_q    <= player_d;
            face_up_q   <= face_up_d;
            matched_q   <= matched_d;
            game_over_q <= game_over_d;
            hold_q      <= hold_d;
            pos1_q      <= pos1_d;
            pos2_q      <= pos2_d;
            last_q      <= last_d;
        end
    end

    // While select is high, state reports the card just picked, so it stays
    // correct even if the cursor moved on the same edge as the pick.
    assign bus.state     = card_at(select_q ? last_q : cursor, shuffle_q);
    assign bus.select    = select_q;
    assign bus.empty     = empty;
    assign bus.player    = player_q;
    assign bus.cursor    = cursor;
    assign bus.face_up   = face_up_q;
    assign bus.matched   = matched_q;
    assign bus.game_over = game_over_q;

endmodule

// File: tb/tb_card_board.sv
// Directed self-checking bench for card_board with a 4-cycle hold.
module tb_card_board;

    logic       clk;
    logic       rst;
    logic [3:0] shuffle;
    int         n_cmp;
    int         n_err;
    int         mrow;
    int         mcol;

    card_board_if bus ();

    card_board #(.HOLD_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .shuffle (shuffle),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 up, 1 down, 2 left, 3 right, 4 select: one-cycle pulse.
    task automatic press(input int which);
        case (which)
            0: bus.btn_up    = 1'b1;
            1: bus.btn_down  = 1'b1;
            2: bus.btn_left  = 1'b1;
            3: bus.btn_right = 1'b1;
            default: bus.btn_sel = 1'b1;
        endcase
        tick();
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
        bus.btn_right = 1'b0; bus.btn_sel = 1'b0;
    endtask

    // Walk to a position using right/down presses only, tracking the cursor locally.
    task automatic goto(input int p);
        while (mcol != p % 4) begin press(3); mcol = (mcol + 1) % 4; end
        while (mrow != p / 4) begin press(1); mrow = (mrow + 1) % 4; end
    endtask

    task automatic do_reset(input logic [3:0] shuf);
        rst = 1'b1; shuffle = shuf;
        tick(); tick();
        rst = 1'b0; shuffle = 4'd0;
        mrow = 0; mcol = 0;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int          pairs [6];
        logic [15:0] exp_m;
        n_cmp = 0; n_err = 0;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0;
        bus.btn_right = 1'b0; bus.btn_sel = 1'b0; bus.turn_res = 2'b00;
        rst = 1'b1; shuffle = 4'd0;
        pairs = '{1, 2, 4, 5, 6, 7};

        // Reset state
        do_reset(4'd0);
        check("rst_cursor",  32'(bus.cursor),    32'd0);
        check("rst_player",  32'(bus.player),    32'd0);
        check("rst_faceup",  32'(bus.face_up),   32'd0);
        check("rst_matched", 32'(bus.matched),   32'd0);
        check("rst_over",    32'(bus.game_over), 32'd0);
        check("rst_select",  32'(bus.select),    32'd0);
        check("rst_empty",   32'(bus.empty),     32'd1);

        // Cursor wrap and move priority
        press(3); press(3); press(3);
        check("right3", 32'(bus.cursor), 32'd3);
        press(3);
        check("right_wrap", 32'(bus.cursor), 32'd0);
        press(0);
        check("up_wrap", 32'(bus.cursor), 32'd12);
        bus.btn_up = 1'b1; bus.btn_right = 1'b1; tick();
        bus.btn_up = 1'b0; bus.btn_right = 1'b0;
        check("prio_up_right", 32'(bus.cursor), 32'd8);
        bus.btn_down = 1'b1; bus.btn_left = 1'b1; tick();
        bus.btn_down = 1'b0; bus.btn_left = 1'b0;
        check("prio_down_left", 32'(bus.cursor), 32'd12);
        press(2);
        check("left_wrap", 32'(bus.cursor), 32'd15);
        bus.btn_left = 1'b1; bus.btn_right = 1'b1; tick();
        bus.btn_left = 1'b0; bus.btn_right = 1'b0;
        check("prio_left_right", 32'(bus.cursor), 32'd14);
        mrow = 3; mcol = 2;

        // Matching pair 0/8
        goto(0);
        press(4);
        check("pick0_select", 32'(bus.select),  32'd1);
        check("pick0_state",  32'(bus.state),   32'd0);
        check("pick0_faceup", 32'(bus.face_up), 32'h0001);
        check("pick0_empty",  32'(bus.empty),   32'd0);
        press(1); mrow = 1;
        check("select_one_cycle", 32'(bus.select), 32'd0);
        goto(8);
        press(4);
        check("pick8_select", 32'(bus.select),  32'd1);
        check("pick8_state",  32'(bus.state),   32'd0);
        wait_n(4);
        check("hold_faceup",  32'(bus.face_up), 32'h0101);
        check("hold_matched", 32'(bus.matched), 32'h0000);
        tick();
        check("match_matched", 32'(bus.matched), 32'h0101);
        check("match_faceup",  32'(bus.face_up), 32'h0000);
        check("match_player",  32'(bus.player),  32'd0);

        // Mismatched pair 1/2
        goto(1); press(4);
        goto(2); press(4);
        check("pick2_state", 32'(bus.state), 32'd2);
        wait_n(5);
        check("miss_faceup",  32'(bus.face_up), 32'h0000);
        check("miss_matched", 32'(bus.matched), 32'h0101);
        check("miss_player",  32'(bus.player),  32'd1);

        // Picking a matched card, and the same card twice, is ignored
        goto(0); press(4);
        check("matched_sel_ignored", 32'(bus.select),  32'd0);
        check("matched_sel_faceup",  32'(bus.face_up), 32'h0000);
        goto(3); press(4);
        check("pick3_select", 32'(bus.select), 32'd1);
        press(4);
        check("dup_sel_ignored", 32'(bus.select),  32'd0);
        check("dup_sel_faceup",  32'(bus.face_up), 32'h0008);
        goto(11); press(4);
        check("pick11_select", 32'(bus.select), 32'd1);
        check("pick11_state",  32'(bus.state),  32'd3);
        wait_n(5);
        check("match3_matched", 32'(bus.matched), 32'h0909);
        check("match3_player",  32'(bus.player),  32'd1);
        check("match3_empty",   32'(bus.empty),   32'd0);

        // Clear the remaining pairs
        exp_m = 16'h0909;
        for (int k = 0; k < 6; k++) begin
            goto(pairs[k]); press(4);
            goto(pairs[k] + 8); press(4);
            exp_m[pairs[k]] = 1'b1;
            exp_m[pairs[k] + 8] = 1'b1;
            wait_n(4);
            if (k == 5) check("over_not_yet", 32'(bus.game_over), 32'd0);
            tick();
            check("pair_matched", 32'(bus.matched), 32'(exp_m));
        end
        check("final_over",    32'(bus.game_over), 32'd1);
        check("final_matched", 32'(bus.matched),   32'hFFFF);
        press(3);
        press(4);
        check("over_select", 32'(bus.select), 32'd0);
        press(0);
        check("over_cursor", 32'(bus.cursor),  32'd15);
        check("over_player", 32'(bus.player),  32'd1);
        check("over_faceup", 32'(bus.face_up), 32'h0000);
        check("over_hold",   32'(bus.game_over), 32'd1);

        // turn_res: 01 leaves the board alone, 11 forces game over
        do_reset(4'd0);
        check("rst2_over",    32'(bus.game_over), 32'd0);
        check("rst2_matched", 32'(bus.matched),   32'd0);
        bus.btn_sel = 1'b1; bus.turn_res = 2'b01; tick();
        bus.btn_sel = 1'b0; bus.turn_res = 2'b00;
        check("tr01_select", 32'(bus.select),    32'd1);
        check("tr01_over",   32'(bus.game_over), 32'd0);
        bus.turn_res = 2'b11; tick(); bus.turn_res = 2'b00;
        check("tr11_over", 32'(bus.game_over), 32'd1);
        press(3);
        check("tr11_cursor", 32'(bus.cursor), 32'd0);

        // Reset in the middle of HOLD
        do_reset(4'd0);
        press(4); goto(1); press(4);
        wait_n(5);
        check("pre_rst_player", 32'(bus.player), 32'd1);
        goto(0); press(4);
        goto(8); press(4);
        wait_n(2);
        rst = 1'b1; tick();
        check("midhold_faceup",  32'(bus.face_up), 32'd0);
        check("midhold_matched", 32'(bus.matched), 32'd0);
        check("midhold_player",  32'(bus.player),  32'd0);
        check("midhold_cursor",  32'(bus.cursor),  32'd0);
        rst = 1'b0; mrow = 0; mcol = 0;
        wait_n(6);
        check("no_resolve_matched", 32'(bus.matched), 32'd0);
        check("no_resolve_faceup",  32'(bus.face_up), 32'd0);

        // Layout rotation with shuffle = 3
        do_reset(4'd3);
        press(4);
        check("shuf_pick0_state", 32'(bus.state), 32'd3);
        goto(5); press(4);
        check("shuf_pick5_state", 32'(bus.state), 32'd0);
        wait_n(5);
        check("shuf_miss_player",  32'(bus.player),  32'd1);
        check("shuf_miss_matched", 32'(bus.matched), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/card_board.md
CARD_BOARD -- requirements
Module: card_board

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000, is the number of clocks both picked cards stay face-up before resolution.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 shuffle  in  4  layout rotation, sampled only while rst=1.
REQ-005 btn_up, btn_down, btn_left, btn_right  in  1 each  debounced single-cycle cursor-move pulses.
REQ-006 btn_sel  in  1  debounced single-cycle pick pulse.
REQ-007 turn_res  in  2  result code from the turn/score stage: 00 none, 01 turn done, 10 winner, 11 tie.
REQ-008 select  out  1  single-cycle pick strobe to the turn/score stage.
REQ-009 state  out  4  card value under the cursor; valid whenever select=1.
REQ-010 empty  out  1  high when the card under the cursor is neither matched nor face-up.
REQ-011 player  out  1  current player: 0 = J1, 1 = J2.
REQ-012 cursor  out  4  board position, row-major on a 4x4 grid.
REQ-013 face_up, matched  out  16 each  per-position display flags.
REQ-014 game_over  out  1  high once play has ended.

Function
REQ-015 Card value at position i SHALL be BOARD_INIT[(i + shuffle_q) mod 16], where shuffle_q is shuffle latched during reset.
REQ-016 Cursor moves SHALL wrap within the row for left/right and within the column for up/down (e.g. right at 3 -> 0, up at 1 -> 13).
REQ-017 If more than one move pulse arrives in the same cycle, the first in the order up, down, left, right SHALL be applied and the rest ignored.
REQ-018 FSM states SHALL be PICK1, PICK2, HOLD, RESOLVE, OVER; the reset state is PICK1.
REQ-019 In PICK1 or PICK2, btn_sel with empty=1 SHALL assert select for exactly the next cycle, set face_up[cursor], and record the position.
REQ-020 btn_sel with empty=0, or btn_sel in any other FSM state, SHALL be ignored.
REQ-021 Transitions: a valid pick in PICK1 -> PICK2; a valid pick in PICK2 -> HOLD.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES clocks, then go to RESOLVE.
REQ-023 RESOLVE (one cycle), values equal: set matched for both positions, clear their face_up, player unchanged.
REQ-024 RESOLVE (one cycle), values differ: clear both face_up bits and toggle player.
REQ-025 RESOLVE SHALL go to OVER if all 16 matched bits are set after the update, otherwise to PICK1.
REQ-026 turn_res of 10 or 11 in any state SHALL force OVER at the next edge.
REQ-027 OVER SHALL hold game_over=1, ignore all buttons, and be left only by rst.
REQ-028 turn_res of 00 or 01 SHALL not change board state.
REQ-029 Cursor moves SHALL be accepted in every state except OVER.
REQ-030 A pick and a move in the same cycle SHALL pick the pre-move position.
REQ-031 empty and state SHALL be combinational from the registered cursor, flags and layout.
REQ-032 The HOLD counter SHALL be $clog2(HOLD_CYCLES+1) bits wide and SHALL never wrap.

Reset
REQ-033 On rst=1 at a clock edge, the following SHALL reset: select=0, player=0, cursor=0, face_up=0, matched=0, game_over=0, FSM=PICK1, HOLD counter=0, shuffle_q=shuffle.
REQ-034 Reset asserted mid-HOLD or in OVER SHALL abandon the turn with no RESOLVE update.

Structure
REQ-035 Package mem_pkg SHALL hold BOARD_INIT (16 x 4-bit, values 0-7 each exactly twice), the FSM state enum, and the turn_res code constants shared with the turn/score stage.
REQ-036 The cursor logic SHALL be a sub-module named cursor_nav (moves, wrap, priority).

Verification (HOLD_CYCLES=4)
REQ-037 shuffle=0, rst, then 3 right pulses -> cursor=3; one more right pulse -> cursor=0; one up pulse -> cursor=12.
REQ-038 Pick position p, then a position q holding the same value -> select pulses twice; 4 HOLD cycles; matched[p]=matched[q]=1, face_up=0, player=0.
REQ-039 Pick a mismatched pair -> after RESOLVE, face_up=0, matched unchanged, player=1.
REQ-040 Pick the same position twice -> second btn_sel gives select=0 and FSM stays PICK2; btn_sel on a matched card -> ignored.
REQ-041 Match all 8 pairs -> game_over=1 one cycle after the final RESOLVE; further buttons change nothing.
REQ-042 turn_res=11 during PICK2 -> OVER next cycle; rst mid-HOLD -> all flags clear and player=0 next cycle.
